// File: rtl/gs_matrix_loader.sv
// Matrix loader: packs w-bit words into l-bit rows, writes k rows,
// then hands the RAM port to gs_elim_ctrl and waits for its done.
module gs_matrix_loader #(
  parameter int k = 6,
  parameter int l = 4,
  parameter int w = 2
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 load_start,
  input  logic                 in_valid,
  input  logic [w-1:0]         in_data,
  output logic                 in_ready,
  output logic                 mem_own,
  output logic [$clog2(k)-1:0] mem_addr,
  output logic [l-1:0]         mem_din,
  output logic                 mem_we,
  output logic                 ge_start,
  input  logic                 ge_done,
  output logic                 busy,
  output logic                 done
);

  localparam int BEATS = l / w;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW = $clog2(k + 1);
  localparam int AW = $clog2(k);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(k - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_KICK,
    S_WAIT,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [BW-1:0] beat_q;
  logic [RW-1:0] row_q;
  logic [l-1:0]  shift_q;
  logic [l-1:0]  row_nxt;
  logic          hs;
  logic          row_end;

  assign hs      = in_valid & (state_q == S_LOAD);
  assign row_end = hs & (beat_q == BEAT_LAST);

  // With one beat per row the incoming word is the whole row.
  generate
    if (BEATS == 1) begin : g_one
      assign row_nxt = in_data;
    end else begin : g_multi
      assign row_nxt = {shift_q[l-w-1:0], in_data};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded handshake/ownership outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    mem_own  = 1'b0;
    busy     = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (load_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        mem_own  = 1'b1;
        if (row_end && row_q == ROW_LAST)
          state_d = S_FLUSH;
      end
      S_FLUSH: begin
        mem_own = 1'b1;
        state_d = S_KICK;
      end
      S_KICK: state_d = S_WAIT;
      S_WAIT: begin
        if (ge_done) state_d = S_FIN;
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat/row counters and the row shift register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      beat_q  <= '0;
      row_q   <= '0;
      shift_q <= '0;
    end else begin
      if (state_q == S_IDLE && load_start) begin
        beat_q <= '0;
        row_q  <= '0;
      end
      if (hs) begin
        shift_q <= row_nxt;
        if (beat_q == BEAT_LAST) begin
          beat_q <= '0;
          row_q  <= row_q + 1'b1;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end
    end
  end

  // Registered RAM write port and controller pulses.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      ge_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_we   <= row_end;
      ge_start <= (state_q == S_FLUSH);
      done     <= (state_q == S_WAIT) & ge_done;
      if (row_end) begin
        mem_addr <= row_q[AW-1:0];
        mem_din  <= row_nxt;
      end
    end
  end

endmodule
